// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through to writeback and runs one
// load/store at a time on a req/ack data-memory port with a 15-cycle timeout.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dest_reg_value_ixmem_p1,
  input  logic [2:0]  dest_reg_index_ixmem_p1,
  input  logic        dest_reg_write_valid_ixmem_p1,
  input  logic [15:0] mem_addr_ixmem_p1,
  input  logic        ldst_valid_ixmem_p1,
  input  logic [1:0]  store_valid_ixmem_p1,
  input  logic [15:0] mem_data_in_ixmem_p1,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        mem_stall_p1,
  output logic [2:0]  dest_reg_index_memwb_p1,
  output logic [15:0] dest_reg_value_memwb_p1,
  output logic        dest_reg_write_valid_memwb_p1,
  output logic        mem_err_p1
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [15:0] val_q;
  logic [1:0]  sv_q;
  logic        req_q, wr_q, err_q, wb_valid_q;
  logic [15:0] addr_q, wdata_q, wb_value_q;
  logic [2:0]  wb_index_q;
  logic        last_wait;

  // cnt_q counts completed wait cycles; the 15th unacknowledged cycle is the last.
  assign last_wait    = (cnt_q == 4'd14);
  assign mem_stall_p1 = ~rst & (state_q == BUSY) & ~dmem_ack & ~last_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      sv_q       <= '0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wb_index_q <= '0;
      wb_value_q <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ldst_valid_ixmem_p1) begin
            wb_index_q <= dest_reg_index_ixmem_p1;
            wb_value_q <= dest_reg_value_ixmem_p1;
            wb_valid_q <= dest_reg_write_valid_ixmem_p1;
          end else if (mem_addr_ixmem_p1[0]) begin
            err_q <= 1'b1;
          end else begin
            req_q   <= 1'b1;
            wr_q    <= store_valid_ixmem_p1[0];
            addr_q  <= mem_addr_ixmem_p1;
            wdata_q <= mem_data_in_ixmem_p1;
            idx_q   <= dest_reg_index_ixmem_p1;
            val_q   <= dest_reg_value_ixmem_p1;
            sv_q    <= store_valid_ixmem_p1;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            state_q    <= IDLE;
            wb_index_q <= idx_q;
            if (!sv_q[0]) begin
              wb_value_q <= dmem_rdata;
              wb_valid_q <= 1'b1;
            end else if (sv_q[1]) begin
              wb_value_q <= val_q;
              wb_valid_q <= 1'b1;
            end
          end else if (last_wait) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req                      = req_q;
  assign dmem_wr                       = wr_q;
  assign dmem_addr                     = addr_q;
  assign dmem_wdata                    = wdata_q;
  assign mem_err_p1                    = err_q;
  assign dest_reg_index_memwb_p1       = wb_index_q;
  assign dest_reg_value_memwb_p1       = wb_value_q;
  assign dest_reg_write_valid_memwb_p1 = wb_valid_q;

endmodule
